i2c_reg_reader: RTL and testbench

- Command sequencer that sits directly upstream of i2c_master and drives its start/addr/rw/data_in inputs.
- Converts one "read N registers from slave S starting at register R" command into a series of single-byte I2C transactions.
- For each byte it issues a pointer write (R+i), then a one-byte read.
- Returned bytes go out on a valid/ready stream to downstream logic (LED/UART display). The block replaces hand-written per-application control FSMs.

---
 rtl/i2c_reg_reader.sv | 159 +++++++++++++++
 tb/tb_i2c_reg_reader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_reader.sv
// Command sequencer for i2c_master: turns "read N registers from slave S at R" into
// pointer-write / single-byte-read pairs and streams the returned bytes downstream.
module i2c_reg_reader #(
  parameter int MAX_LEN      = 16,
  parameter int LEN_W        = $clog2(MAX_LEN + 1),
  parameter int BUSY_TIMEOUT = 1024,
  parameter int GAP_CYCLES   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [6:0]       cmd_slave_addr,
  input  logic [7:0]       cmd_reg_addr,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             rd_last,
  output logic             done,
  output logic             error,
  output logic             i2c_start,
  output logic [6:0]       i2c_slave_addr,
  output logic             i2c_rw,
  output logic [7:0]       data2send,
  input  logic             i2c_busy,
  input  logic [7:0]       received_data
);

  localparam int TMR_W = $clog2(BUSY_TIMEOUT + GAP_CYCLES + 1);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] PTR_GO   = 4'd1;
  localparam logic [3:0] PTR_ACK  = 4'd2;
  localparam logic [3:0] PTR_RUN  = 4'd3;
  localparam logic [3:0] PTR_GAP  = 4'd4;
  localparam logic [3:0] RD_GO    = 4'd5;
  localparam logic [3:0] RD_ACK   = 4'd6;
  localparam logic [3:0] RD_RUN   = 4'd7;
  localparam logic [3:0] OUT      = 4'd8;
  localparam logic [3:0] NEXT_GAP = 4'd9;

  logic [3:0]       state;
  logic [6:0]       slave_reg;
  logic [7:0]       reg_base;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] idx;
  logic [TMR_W-1:0] timer;
  logic             rw_reg;
  logic [7:0]       data_reg;
  logic             done_reg;
  logic             error_reg;
  logic             is_last;

  assign is_last        = (idx == len_reg - LEN_W'(1));
  assign cmd_ready      = (state == IDLE) && !i2c_busy;
  assign i2c_start      = (state == PTR_GO) || (state == RD_GO);
  assign i2c_slave_addr = slave_reg;
  assign i2c_rw         = rw_reg;
  // Pointer wraps naturally in 8 bits (0xFF + 1 -> 0x00).
  assign data2send      = reg_base + 8'(idx);
  assign rd_data        = data_reg;
  assign rd_valid       = (state == OUT);
  assign rd_last        = (state == OUT) && is_last;
  assign done           = done_reg;
  assign error          = error_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      slave_reg <= '0;
      reg_base  <= '0;
      len_reg   <= '0;
      idx       <= '0;
      timer     <= '0;
      rw_reg    <= 1'b0;
      data_reg  <= '0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            slave_reg <= cmd_slave_addr;
            reg_base  <= cmd_reg_addr;
            len_reg   <= cmd_len;
            idx       <= '0;
            rw_reg    <= 1'b0;
            if (cmd_len == '0)
              done_reg <= 1'b1;
            else if (cmd_len > LEN_W'(MAX_LEN))
              error_reg <= 1'b1;
            else
              state <= PTR_GO;
          end
        end
        PTR_GO, RD_GO: begin
          // Timer value k means k cycles have elapsed since the start pulse.
          timer <= TMR_W'(1);
          state <= (state == PTR_GO) ? PTR_ACK : RD_ACK;
        end
        PTR_ACK, RD_ACK: begin
          if (i2c_busy) begin
            state <= (state == PTR_ACK) ? PTR_RUN : RD_RUN;
          end else if (timer == TMR_W'(BUSY_TIMEOUT - 1)) begin
            error_reg <= 1'b1;
            state     <= IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        PTR_RUN: begin
          if (!i2c_busy) begin
            timer <= '0;
            state <= PTR_GAP;
          end
        end
        PTR_GAP: begin
          if (timer == TMR_W'(GAP_CYCLES - 1)) begin
            rw_reg <= 1'b1;
            state  <= RD_GO;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        RD_RUN: begin
          if (!i2c_busy) begin
            data_reg <= received_data;
            state    <= OUT;
          end
        end
        OUT: begin
          if (rd_ready) begin
            if (is_last) begin
              done_reg <= 1'b1;
              state    <= IDLE;
            end else begin
              idx   <= idx + LEN_W'(1);
              timer <= '0;
              state <= NEXT_GAP;
            end
          end
        end
        NEXT_GAP: begin
          if (timer == TMR_W'(GAP_CYCLES - 1)) begin
            rw_reg <= 1'b0;
            state  <= PTR_GO;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_reader.sv
// Directed bench for i2c_reg_reader with a behavioural i2c_master model
// (busy 3 cycles after start for 40 cycles, read byte = pointer ^ 0xA5).
module tb_i2c_reg_reader;

  localparam int MAX_LEN      = 16;
  localparam int LEN_W        = $clog2(MAX_LEN + 1);
  localparam int BUSY_TIMEOUT = 1024;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [6:0]       cmd_slave_addr = '0;
  logic [7:0]       cmd_reg_addr = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             rd_ready = 1'b1;
  logic             rd_last;
  logic             done;
  logic             error;
  logic             i2c_start;
  logic [6:0]       i2c_slave_addr;
  logic             i2c_rw;
  logic [7:0]       data2send;
  logic             i2c_busy;
  logic [7:0]       received_data;

  i2c_reg_reader #(.MAX_LEN(MAX_LEN), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_slave_addr(cmd_slave_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_len(cmd_len),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .done(done), .error(error),
    .i2c_start(i2c_start), .i2c_slave_addr(i2c_slave_addr), .i2c_rw(i2c_rw),
    .data2send(data2send), .i2c_busy(i2c_busy), .received_data(received_data)
  );

  always #5 clk = ~clk;

  // Behavioural master
  logic       mute = 1'b0;
  int         mcnt = 0;
  logic [7:0] mptr = '0;
  assign i2c_busy      = (mcnt >= 3);
  assign received_data = mptr ^ 8'hA5;
  always @(posedge clk) begin
    if (i2c_start && !mute) begin
      mcnt <= 1;
      if (!i2c_rw) mptr <= data2send;
    end else if (mcnt == 42) mcnt <= 0;
    else if (mcnt != 0) mcnt <= mcnt + 1;
  end

  // Monitor
  int          cyc = 0;
  logic [15:0] start_q[$];
  logic [8:0]  rd_q[$];
  int          done_cnt = 0, error_cnt = 0, overlap_cnt = 0;
  int          last_start_cyc = 0, last_done_cyc = 0, last_err_cyc = 0, last_acc_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (reset_n) begin
      if (i2c_start) begin
        start_q.push_back({i2c_rw, i2c_slave_addr, data2send});
        last_start_cyc = cyc;
        if (rd_valid) overlap_cnt++;
      end
      if (rd_valid && rd_ready) rd_q.push_back({rd_last, rd_data});
      if (done) begin done_cnt++; last_done_cyc = cyc; end
      if (error) begin error_cnt++; last_err_cyc = cyc; end
      if (cmd_valid && cmd_ready) last_acc_cyc = cyc;
    end
  end

  int n_checks = 0, n_fail = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [6:0] s, input logic [7:0] r, input int len);
    int ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (cmd_ready) begin ok = 1; break; end
    end
    check_value("cmd_ready_wait", ok, 1);
    cmd_slave_addr = s; cmd_reg_addr = r; cmd_len = LEN_W'(len);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int d0 = done_cnt, e0 = error_cnt, ended = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt != d0 || error_cnt != e0) begin ended = 1; break; end
    end
    check_value(tag, ended, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_seq(input string tag, input logic [6:0] s, input int n,
                           input logic [7:0] ptrs[3], input logic [7:0] bytes[3]);
    check_value({tag, "_starts"}, start_q.size(), 2 * n);
    check_value({tag, "_bytes"}, rd_q.size(), n);
    for (int k = 0; k < n; k++) begin
      if (2 * k + 1 < start_q.size()) begin
        check_value($sformatf("%s_ptr%0d", tag, k), start_q[2*k], {1'b0, s, ptrs[k]});
        check_value($sformatf("%s_rd%0d", tag, k), start_q[2*k+1][15:8], {1'b1, s});
      end
      if (k < rd_q.size())
        check_value($sformatf("%s_data%0d", tag, k), rd_q[k], {(k == n - 1) ? 1'b1 : 1'b0, bytes[k]});
    end
    $display("%s: %0d starts, %0d bytes, done=%0d error=%0d", tag, start_q.size(), rd_q.size(),
             done_cnt, error_cnt);
  endtask

  initial begin
    logic [7:0] p[3];
    logic [7:0] b[3];
    int d0, e0, s0, bad_data, bad_start, seen;

    repeat (3) @(posedge clk);
    #1;
    check_value("rst_start", i2c_start, 0);
    check_value("rst_rd_valid", rd_valid, 0);
    check_value("rst_done_error", {done, error}, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_value("post_rst_ready", cmd_ready, 1);

    // Three bytes from 0x10
    start_q.delete(); rd_q.delete(); d0 = done_cnt; e0 = error_cnt;
    send_cmd(7'h48, 8'h10, 3);
    wait_end("cmd1_end", 2000);
    p = '{8'h10, 8'h11, 8'h12}; b = '{8'hB5, 8'hB4, 8'hB7};
    check_seq("cmd1", 7'h48, 3, p, b);
    check_value("cmd1_done", done_cnt - d0, 1);
    check_value("cmd1_error", error_cnt - e0, 0);

    // Pointer wrap
    start_q.delete(); rd_q.delete(); d0 = done_cnt;
    send_cmd(7'h48, 8'hFE, 3);
    wait_end("cmd2_end", 2000);
    p = '{8'hFE, 8'hFF, 8'h00}; b = '{8'h5B, 8'h5A, 8'hA5};
    check_seq("wrap", 7'h48, 3, p, b);
    check_value("wrap_done", done_cnt - d0, 1);

    // Backpressure stall of 200 cycles on the first byte
    start_q.delete(); rd_q.delete(); d0 = done_cnt;
    rd_ready = 1'b0;
    send_cmd(7'h48, 8'h10, 2);
    seen = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (rd_valid) begin seen = 1; break; end
    end
    check_value("stall_valid_seen", seen, 1);
    s0 = start_q.size(); bad_data = 0; bad_start = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (rd_data !== 8'hB5 || rd_valid !== 1'b1) bad_data++;
      if (i2c_start) bad_start++;
    end
    check_value("stall_data_held", bad_data, 0);
    check_value("stall_no_start", bad_start, 0);
    check_value("stall_start_q", start_q.size(), s0);
    rd_ready = 1'b1;
    wait_end("stall_end", 2000);
    p = '{8'h10, 8'h11, 8'h00}; b = '{8'hB5, 8'hB4, 8'h00};
    check_seq("stall", 7'h48, 2, p, b);
    check_value("stall_done", done_cnt - d0, 1);

    // Master never responds
    mute = 1'b1; d0 = done_cnt; e0 = error_cnt; start_q.delete(); rd_q.delete();
    send_cmd(7'h50, 8'h20, 1);
    wait_end("timeout_end", BUSY_TIMEOUT + 100);
    check_value("timeout_error", error_cnt - e0, 1);
    check_value("timeout_done", done_cnt - d0, 0);
    check_value("timeout_latency", last_err_cyc - last_start_cyc, BUSY_TIMEOUT);
    check_value("timeout_ready", cmd_ready, 1);
    $display("timeout: start cycle %0d error cycle %0d", last_start_cyc, last_err_cyc);
    mute = 1'b0;

    // Zero-length and oversize commands
    start_q.delete(); d0 = done_cnt; e0 = error_cnt;
    send_cmd(7'h48, 8'h10, 0);
    repeat (3) @(posedge clk); #1;
    check_value("len0_done", done_cnt - d0, 1);
    check_value("len0_latency", last_done_cyc - last_acc_cyc, 1);
    check_value("len0_error", error_cnt - e0, 0);
    d0 = done_cnt;
    send_cmd(7'h48, 8'h10, MAX_LEN + 1);
    repeat (3) @(posedge clk); #1;
    check_value("ovf_error", error_cnt - e0, 1);
    check_value("ovf_latency", last_err_cyc - last_acc_cyc, 1);
    check_value("ovf_done", done_cnt - d0, 0);
    check_value("len0_ovf_starts", start_q.size(), 0);
    $display("len0/ovf: done=%0d error=%0d starts=%0d", done_cnt, error_cnt, start_q.size());

    // Reset while the master is busy
    send_cmd(7'h48, 8'h10, 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i2c_busy) begin seen = 1; break; end
    end
    check_value("rst_busy_seen", seen, 1);
    reset_n = 1'b0;
    #1;
    check_value("rstb_outputs",
                {i2c_start, i2c_rw, i2c_slave_addr, data2send, rd_valid, rd_last, done, error, cmd_ready},
                0);
    check_value("rstb_rd_data", rd_data, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check_value("rstb_ready_busy", cmd_ready, 0);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (!i2c_busy) begin seen = 1; break; end
    end
    check_value("rstb_busy_fell", seen, 1);
    check_value("rstb_ready_after", cmd_ready, 1);
    $display("reset: cmd_ready=%0d after busy dropped", cmd_ready);

    check_value("no_valid_with_start", overlap_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
